// File: rtl/fir_mc_decim_filter.sv
// Multi-channel time-multiplexed FIR with shared programmable coefficients,
// per-channel decimation and flush. Single-cycle registered output.
//
// Ports:
//   clk, rst (sync, active-high)
//   in_valid/in_ch/x_in   : channel-tagged input sample
//   coef_we/idx/data      : coefficient bank write (shared by all channels)
//   decim                 : decimation factor (0 -> 1, >DMAX -> DMAX)
//   flush                 : clear delay lines and phases, keep coefficients
//   out_valid/out_ch/y_out: one-cycle output pulse, values held otherwise
module fir_mc_decim_filter #(
  parameter int WIDTH = 16,
  parameter int N     = 8,
  parameter int CH    = 2,
  parameter int DMAX  = 4,
  localparam int CHW   = (CH > 1) ? $clog2(CH) : 1,
  localparam int IDXW  = $clog2(N),
  localparam int DW    = $clog2(DMAX) + 1,
  localparam int ACC_W = 2*WIDTH + $clog2(N) + 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic [CHW-1:0]          in_ch,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic                    coef_we,
  input  logic [IDXW-1:0]         coef_idx,
  input  logic signed [WIDTH-1:0] coef_data,
  input  logic [DW-1:0]           decim,
  input  logic                    flush,
  output logic                    out_valid,
  output logic [CHW-1:0]          out_ch,
  output logic signed [ACC_W-1:0] y_out
);

  localparam int PW = 2*WIDTH;

  logic signed [WIDTH-1:0] h [N];
  logic signed [WIDTH-1:0] t [CH][N-1];
  logic [DW-1:0]           ph [CH];

  logic                    ch_ok;
  logic                    accept;
  logic [CHW-1:0]          cidx;
  logic [DW-1:0]           d_eff;
  logic [DW-1:0]           cur_ph;
  logic [DW:0]             inc_ph;
  logic [DW-1:0]           nxt_ph;
  logic signed [PW-1:0]    prod [N];
  logic signed [ACC_W-1:0] acc;

  // A power-of-two channel count makes every in_ch encoding valid.
  if ((1 << CHW) == CH) begin : g_ch_full
    assign ch_ok = 1'b1;
  end else begin : g_ch_part
    localparam logic [CHW-1:0] CHL = CHW'(CH);
    assign ch_ok = (in_ch < CHL);
  end

  assign accept = in_valid & ch_ok & ~flush;
  assign cidx   = ch_ok ? in_ch : '0;

  always_comb begin
    d_eff = decim;
    if (decim == '0)
      d_eff = DW'(1);
    else if (decim > DW'(DMAX))
      d_eff = DW'(DMAX);
  end

  // A phase at or beyond the (possibly lowered) factor wraps to 0.
  assign cur_ph = ph[cidx];
  assign inc_ph = {1'b0, cur_ph} + 1'b1;
  assign nxt_ph = (inc_ph >= {1'b0, d_eff}) ? '0 : inc_ph[DW-1:0];

  always_comb begin
    prod[0] = x_in * h[0];
    for (int k = 1; k < N; k++)
      prod[k] = t[cidx][k-1] * h[k];
  end

  always_comb begin
    acc = '0;
    for (int k = 0; k < N; k++)
      acc = acc + {{(ACC_W-PW){prod[k][PW-1]}}, prod[k]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < N; k++)
        h[k] <= '0;
      for (int c = 0; c < CH; c++) begin
        ph[c] <= '0;
        for (int k = 0; k < N-1; k++)
          t[c][k] <= '0;
      end
      out_valid <= 1'b0;
      out_ch    <= '0;
      y_out     <= '0;
    end else begin
      if (coef_we)
        h[coef_idx] <= coef_data;
      out_valid <= 1'b0;
      if (flush) begin
        for (int c = 0; c < CH; c++) begin
          ph[c] <= '0;
          for (int k = 0; k < N-1; k++)
            t[c][k] <= '0;
        end
      end else if (accept) begin
        t[cidx][0] <= x_in;
        for (int k = 1; k < N-1; k++)
          t[cidx][k] <= t[cidx][k-1];
        ph[cidx] <= nxt_ph;
        if (cur_ph == '0) begin
          out_valid <= 1'b1;
          out_ch    <= in_ch;
          y_out     <= acc;
        end
      end
    end
  end

endmodule

// File: tb/tb_fir_mc_decim_filter.sv
// Directed self-checking bench for fir_mc_decim_filter.
// Uses CH=3 so that an out-of-range channel tag can be driven.
module tb_fir_mc_decim_filter;

  localparam int WIDTH = 16;
  localparam int N     = 8;
  localparam int CH    = 3;
  localparam int DMAX  = 4;
  localparam int ACC_W = 36;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    in_valid;
  logic [1:0]              in_ch;
  logic signed [WIDTH-1:0] x_in;
  logic                    coef_we;
  logic [2:0]              coef_idx;
  logic signed [WIDTH-1:0] coef_data;
  logic [2:0]              decim;
  logic                    flush;
  logic                    out_valid;
  logic [1:0]              out_ch;
  logic signed [ACC_W-1:0] y_out;

  int checks = 0;
  int errors = 0;

  fir_mc_decim_filter #(
    .WIDTH(WIDTH), .N(N), .CH(CH), .DMAX(DMAX)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ch(in_ch), .x_in(x_in),
    .coef_we(coef_we), .coef_idx(coef_idx),
    .coef_data(coef_data), .decim(decim), .flush(flush),
    .out_valid(out_valid), .out_ch(out_ch), .y_out(y_out)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0; coef_we = 1'b0; flush = 1'b0;
  endtask

  task automatic send(input logic [1:0] ch, input int x);
    in_valid = 1'b1; in_ch = ch; x_in = WIDTH'(x);
    cyc();
    in_valid = 1'b0;
  endtask

  task automatic wr_coef(input int idx, input int v);
    coef_we = 1'b1; coef_idx = 3'(idx); coef_data = WIDTH'(v);
    cyc();
    coef_we = 1'b0;
  endtask

  task automatic load_ramp();
    for (int k = 0; k < N; k++) wr_coef(k, k + 1);
  endtask

  task automatic load_all(input int v);
    for (int k = 0; k < N; k++) wr_coef(k, v);
  endtask

  task automatic do_flush();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); in_ch = '0; x_in = '0;
    coef_idx = '0; coef_data = '0; decim = 3'd1;
    repeat (3) cyc();
    checks++;
    if (out_valid !== 1'b0 || out_ch !== 2'd0 || y_out !== '0) begin
      errors++;
      $display("FAIL reset: v=%b ch=%0d y=%0d, want 0 0 0",
               out_valid, out_ch, y_out);
    end
    rst = 1'b0;
    cyc();
  endtask

  task automatic test_ramp();
    logic signed [ACC_W-1:0] e [16] = '{1, 4, 10, 20, 35, 56, 84, 120,
      156, 192, 228, 264, 300, 336, 372, 408};
    load_ramp();
    decim = 3'd1;
    do_flush();
    for (int i = 0; i < 16; i++) begin
      send(2'd0, i + 1);
      checks++;
      if (out_valid !== 1'b1 || out_ch !== 2'd0 || y_out !== e[i]) begin
        errors++;
        $display("FAIL ramp[%0d]: v=%b ch=%0d y=%0d, want 1 0 %0d",
                 i, out_valid, out_ch, y_out, e[i]);
      end
    end
  endtask

  task automatic test_interleave();
    logic signed [ACC_W-1:0] e0 [10] = '{1, 4, 10, 20, 35, 56, 84, 120,
      156, 192};
    logic signed [ACC_W-1:0] e1 [10] = '{-100, -200, -300, -400, -500,
      -600, -700, -800, 0, 0};
    decim = 3'd0;
    do_flush();
    for (int i = 0; i < 10; i++) begin
      send(2'd0, i + 1);
      checks++;
      if (out_valid !== 1'b1 || out_ch !== 2'd0 || y_out !== e0[i]) begin
        errors++;
        $display("FAIL ilv ch0[%0d]: v=%b ch=%0d y=%0d, want 1 0 %0d",
                 i, out_valid, out_ch, y_out, e0[i]);
      end
      send(2'd1, (i == 0) ? -100 : 0);
      checks++;
      if (out_valid !== 1'b1 || out_ch !== 2'd1 || y_out !== e1[i]) begin
        errors++;
        $display("FAIL ilv ch1[%0d]: v=%b ch=%0d y=%0d, want 1 1 %0d",
                 i, out_valid, out_ch, y_out, e1[i]);
      end
    end
  endtask

  task automatic test_decim();
    logic signed [ACC_W-1:0] e [5] = '{1, 10, 35, 84, 156};
    logic [4:0] pat = 5'b10001;
    logic [4:0] got;
    decim = 3'd2;
    do_flush();
    for (int i = 0; i < 10; i++) begin
      send(2'd0, i + 1);
      checks++;
      if ((i % 2) == 0) begin
        if (out_valid !== 1'b1 || y_out !== e[i/2]) begin
          errors++;
          $display("FAIL decim2[%0d]: v=%b y=%0d, want 1 %0d",
                   i, out_valid, y_out, e[i/2]);
        end
      end else if (out_valid !== 1'b0 || y_out !== e[i/2]) begin
        errors++;
        $display("FAIL decim2 hold[%0d]: v=%b y=%0d, want 0 %0d",
                 i, out_valid, y_out, e[i/2]);
      end
    end
    decim = 3'd7;
    do_flush();
    for (int i = 0; i < 5; i++) begin
      send(2'd0, 1);
      got[i] = out_valid;
    end
    checks++;
    if (got !== pat) begin
      errors++;
      $display("FAIL decim clamp: pattern=%b, want %b", got, pat);
    end
    decim = 3'd4;
    do_flush();
    for (int i = 0; i < 3; i++) send(2'd0, 1);
    decim = 3'd2;
    send(2'd0, 1);
    got[0] = out_valid;
    send(2'd0, 1);
    got[1] = out_valid;
    checks++;
    if (got[1:0] !== 2'b10) begin
      errors++;
      $display("FAIL decim drop: got=%b, want 10", got[1:0]);
    end
  endtask

  task automatic test_extremes();
    decim = 3'd1;
    load_all(-32768);
    do_flush();
    for (int i = 0; i < 8; i++) send(2'd2, -32768);
    checks++;
    if (out_valid !== 1'b1 || out_ch !== 2'd2 ||
        y_out !== 36'sd8589934592) begin
      errors++;
      $display("FAIL extreme neg*neg: v=%b ch=%0d y=%0d, want 1 2 8589934592",
               out_valid, out_ch, y_out);
    end
    load_all(32767);
    do_flush();
    for (int i = 0; i < 8; i++) send(2'd2, -32768);
    checks++;
    if (out_valid !== 1'b1 || y_out !== -36'sd8589672448) begin
      errors++;
      $display("FAIL extreme pos*neg: v=%b y=%0d, want 1 -8589672448",
               out_valid, y_out);
    end
  endtask

  task automatic test_flush();
    load_ramp();
    decim = 3'd1;
    do_flush();
    for (int i = 0; i < 5; i++) send(2'd0, i + 1);
    flush = 1'b1;
    send(2'd0, 6);
    flush = 1'b0;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush+valid: v=%b, want 0", out_valid);
    end
    send(2'd0, 1);
    checks++;
    if (out_valid !== 1'b1 || y_out !== 36'sd1) begin
      errors++;
      $display("FAIL after flush: v=%b y=%0d, want 1 1", out_valid, y_out);
    end
    send(2'd0, 2);
    rst = 1'b1;
    cyc();
    checks++;
    if (out_valid !== 1'b0 || out_ch !== 2'd0 || y_out !== '0) begin
      errors++;
      $display("FAIL mid reset: v=%b ch=%0d y=%0d, want 0 0 0",
               out_valid, out_ch, y_out);
    end
    rst = 1'b0;
    send(2'd1, 5);
    checks++;
    if (out_valid !== 1'b1 || out_ch !== 2'd1 || y_out !== '0) begin
      errors++;
      $display("FAIL no coefs: v=%b ch=%0d y=%0d, want 1 1 0",
               out_valid, out_ch, y_out);
    end
  endtask

  task automatic test_back_to_back();
    load_ramp();
    decim = 3'd1;
    do_flush();
    coef_we = 1'b1; coef_idx = 3'd0; coef_data = 16'sd5;
    send(2'd0, 1);
    coef_we = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || y_out !== 36'sd1) begin
      errors++;
      $display("FAIL coef same cycle: v=%b y=%0d, want 1 1",
               out_valid, y_out);
    end
    send(2'd0, 0);
    checks++;
    if (out_valid !== 1'b1 || y_out !== 36'sd2) begin
      errors++;
      $display("FAIL coef next: v=%b y=%0d, want 1 2", out_valid, y_out);
    end
    send(2'd3, 77);
    checks++;
    if (out_valid !== 1'b0 || y_out !== 36'sd2) begin
      errors++;
      $display("FAIL bad ch: v=%b y=%0d, want 0 2", out_valid, y_out);
    end
    send(2'd0, 0);
    checks++;
    if (out_valid !== 1'b1 || out_ch !== 2'd0 || y_out !== 36'sd3) begin
      errors++;
      $display("FAIL bad ch state: v=%b ch=%0d y=%0d, want 1 0 3",
               out_valid, out_ch, y_out);
    end
  endtask

  initial begin
    test_reset();
    test_ramp();
    test_interleave();
    test_decim();
    test_extremes();
    test_flush();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
